seg_scan_driver: RTL and testbench

Upstream feeder for the 4-bit-to-7-segment decoder: accepts a 14-bit binary value, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a 4-digit common-anode display. Each refresh slot drives one digit code on `digit` (wired to the decoder's `N` input) and the matching active-low anode enable on `an`. Sits between the arithmetic/counter logic that produces display values and the segment decoder.

---
 rtl/seg_scan_driver_if.sv | 13 +
 rtl/seg_scan_driver.sv | 119 +++++++++++
 tb/tb_seg_scan_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Handshake and display bus between a value producer and seg_scan_driver.
// The master loads values; the slave converts them and scans the display.
`timescale 1ns/1ps
interface seg_scan_driver_if;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic [3:0]  digit;
    logic [3:0]  an;

    modport master (output value, load, input busy, digit, an);
    modport slave  (input value, load, output busy, digit, an);
endinterface

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD (double-dabble) converter feeding a 4-digit multiplexed
// common-anode display scanner with optional leading-zero blanking.
`timescale 1ns/1ps
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input logic              clk,
    input logic              rst,
    seg_scan_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam logic [13:0] MAX_VALUE  = 14'd9999;
    localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

    state_t          state;
    logic            busy_q;
    logic [13:0]     bin_q;
    logic [15:0]     bcd_q;
    logic [15:0]     bcd_adj;
    logic [3:0]      shift_cnt;
    logic            err_pend;
    logic [3:0][3:0] disp_q;
    logic            disp_err;

    logic [15:0]     presc_q;
    logic [1:0]      slot_q;
    logic [1:0]      slot_nxt;
    logic [3:0]      upper_zero;
    logic            blank_nxt;
    logic [3:0]      digit_q;
    logic [3:0]      an_q;

    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the four display registers are plain flops, so they are reset like any other state.
            state     <= IDLE;
            busy_q    <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            shift_cnt <= '0;
            err_pend  <= 1'b0;
            disp_q    <= '0;
            disp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        busy_q    <= 1'b1;
                        bcd_q     <= '0;
                        shift_cnt <= '0;
                        if (bus.value <= MAX_VALUE) begin
                            bin_q    <= bus.value;
                            err_pend <= 1'b0;
                            state    <= CONV;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= COMMIT;
                        end
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    shift_cnt      <= shift_cnt + 4'd1;
                    if (shift_cnt == 4'd13)
                        state <= COMMIT;
                end
                COMMIT: begin
                    disp_q   <= bcd_q;
                    disp_err <= err_pend;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot outputs are prepared for the slot being entered, from the current display registers.
    assign slot_nxt = slot_q + 2'd1;

    always_comb begin
        upper_zero[3] = (disp_q[3] == 4'd0);
        for (int i = 2; i >= 0; i--)
            upper_zero[i] = upper_zero[i+1] && (disp_q[i] == 4'd0);
        blank_nxt = BLANK_LZ && !disp_err && (slot_nxt != 2'd0) && upper_zero[slot_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            slot_q  <= '0;
            digit_q <= 4'h0;
            an_q    <= 4'b1110;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            slot_q  <= slot_nxt;
            digit_q <= disp_err ? 4'hE : disp_q[slot_nxt];
            an_q    <= blank_nxt ? 4'b1111 : ~(4'b0001 << slot_nxt);
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.digit = digit_q;
    assign bus.an    = an_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed and random stimulus for seg_scan_driver with and without blanking,
// checked every cycle against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_seg_scan_driver;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b0;
    logic [13:0] value = '0;

    int vectors = 0;
    int miscompares = 0;

    seg_scan_driver_if ifa ();
    seg_scan_driver_if ifb ();

    assign ifa.value = value;
    assign ifa.load  = load;
    assign ifb.value = value;
    assign ifb.load  = load;

    seg_scan_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    seg_scan_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    // Reference model: edge counter since reset, commit schedule, committed decimal value.
    int n = 0;
    int commit_edge = 0;
    int pend_val = 0;
    bit pend_err = 1'b0;
    int cv = 0;
    bit cerr = 1'b0;
    bit exp_busy = 1'b0;
    logic [3:0] ed_a = 4'h0, ea_a = 4'b1110, ed_b = 4'h0, ea_b = 4'b1110;

    function automatic void slot_exp(input int s, input bit blank_lz,
                                     output logic [3:0] d, output logic [3:0] a);
        int p = 1;
        for (int i = 0; i < s; i++) p *= 10;
        if (cerr) begin
            d = 4'hE;
            a = ~(4'b0001 << s);
        end else begin
            d = 4'((cv / p) % 10);
            a = (blank_lz && s > 0 && cv < p) ? 4'b1111 : ~(4'b0001 << s);
        end
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            n = 0; commit_edge = 0; cv = 0; cerr = 1'b0; exp_busy = 1'b0;
            ed_a = 4'h0; ea_a = 4'b1110; ed_b = 4'h0; ea_b = 4'b1110;
        end else begin
            n++;
            if (n % R == 0) begin
                slot_exp((n / R) % 4, 1'b1, ed_a, ea_a);
                slot_exp((n / R) % 4, 1'b0, ed_b, ea_b);
            end
            if (n == commit_edge) begin
                cv = pend_val;
                cerr = pend_err;
            end else if (load && n > commit_edge) begin
                if (int'(value) <= 9999) begin
                    pend_val = int'(value); pend_err = 1'b0; commit_edge = n + 15;
                end else begin
                    pend_val = 0; pend_err = 1'b1; commit_edge = n + 1;
                end
            end
            exp_busy = (n < commit_edge);
        end
        #1;
        check("busy_a",  {3'b0, ifa.busy}, {3'b0, exp_busy});
        check("busy_b",  {3'b0, ifb.busy}, {3'b0, exp_busy});
        check("digit_a", ifa.digit, ed_a);
        check("an_a",    ifa.an,    ea_a);
        check("digit_b", ifb.digit, ed_b);
        check("an_b",    ifb.an,    ea_b);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic do_load(input int v);
        value = 14'(v);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // Reset, then idle scanning of value 0.
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(24);

        // 1234: four distinct digits across all slots.
        do_load(1234);
        run(40);

        // 7: blanked slots 1..3 on dut_a, shown as zeros on dut_b.
        do_load(7);
        run(36);

        // Largest legal value, then overflow.
        do_load(9999);
        run(36);
        do_load(10000);
        run(24);

        // A load while busy is dropped.
        do_load(4321);
        run(4);
        do_load(55);
        run(40);

        // Reset mid-conversion discards both the conversion and the display.
        do_load(8888);
        run(36);
        do_load(1234);
        run(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(24);

        // Values straddling the blanking thresholds.
        do_load(10);   run(36);
        do_load(100);  run(36);
        do_load(1000); run(36);
        do_load(16383); run(20);
        do_load(0);    run(36);

        // load held high with changing values.
        load = 1'b1;
        for (int i = 0; i < 80; i++) begin
            value = 14'($urandom_range(0, 12000));
            tick();
        end
        load = 1'b0;
        run(20);

        // Random loads with random gaps (some land while busy).
        for (int i = 0; i < 40; i++) begin
            do_load(int'($urandom_range(0, 11000)));
            run(int'($urandom_range(0, 30)));
        end
        run(36);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
